stackcalc_engine: RTL and testbench

//  Parametrised stack calculator core, successor to the single-register push-only calculator.

---
 rtl/stackcalc_if.sv | 13 +
 rtl/stackcalc_engine.sv | 120 ++++++++++++
 tb/tb_stackcalc_engine.sv | 129 ++++++++++++
 3 files changed

// File: rtl/stackcalc_if.sv
// stackcalc_if: operand/opcode stream and stack status bundle for stackcalc_engine
interface stackcalc_if #(parameter int WIDTH = 4, parameter int DEPTH = 8);
  logic in_valid;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] top;
  logic [$clog2(DEPTH):0] depth;
  logic arg_pend;
  logic ovf;
  logic unf;
  logic ill;
  modport master (output in_valid, in_data, input top, depth, arg_pend, ovf, unf, ill);
  modport slave (input in_valid, in_data, output top, depth, arg_pend, ovf, unf, ill);
endinterface

// File: rtl/stackcalc_engine.sv
// stackcalc_engine: LIFO stack calculator with sticky ovf/unf/ill flags
// Optional MUL opcode 0x8 enabled by defining STACKCALC_MUL_EN.
module stackcalc_engine #(parameter int WIDTH = 4, parameter int DEPTH = 8) (
  input logic clk,
  input logic rst,
  stackcalc_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {OP, ARG} state_t;
  state_t state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] dep, nxt_dep;
  logic [WIDTH-1:0] top_r, nxt_top, t, s, res, d0, d1;
  logic [AW-1:0] ti, si, fi, a0, a1;
  logic [3:0] op;
  logic we0, we1, set_ovf, set_unf, set_ill, clr, has1, has2, full, is_bin;
  logic ovf_r, unf_r, ill_r;
  assign op = bus.in_data[3:0];
  assign fi = dep[AW-1:0];
  assign ti = fi - AW'(1);
  assign si = fi - AW'(2);
  assign t = mem[ti];
  assign s = mem[si];
  assign has1 = dep != '0;
  assign has2 = dep >= (AW+1)'(2);
  assign full = dep == (AW+1)'(DEPTH);
`ifdef STACKCALC_MUL_EN
  assign is_bin = op inside {4'h3, 4'h4, 4'h8};
  assign res = op == 4'h3 ? s + t : op == 4'h4 ? s - t : s * t;
`else
  assign is_bin = op inside {4'h3, 4'h4};
  assign res = op == 4'h3 ? s + t : s - t;
`endif
  always_comb begin
    nxt_dep = dep;
    nxt_top = top_r;
    we0 = 1'b0;
    we1 = 1'b0;
    a0 = fi;
    a1 = si;
    d0 = t;
    d1 = t;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    set_ill = 1'b0;
    clr = 1'b0;
    if (bus.in_valid && state == ARG) begin
      if (full) set_ovf = 1'b1;
      else begin
        we0 = 1'b1;
        d0 = bus.in_data;
        nxt_dep = dep + 1'b1;
        nxt_top = bus.in_data;
      end
    end else if (bus.in_valid) begin
      case (op)
        4'h0, 4'h1: ;
        4'h2: if (!has1) set_unf = 1'b1;
        else begin
          nxt_dep = dep - 1'b1;
          nxt_top = has2 ? s : '0;
        end
        4'h5: if (!has1) set_unf = 1'b1;
        else if (full) set_ovf = 1'b1;
        else begin
          we0 = 1'b1;
          nxt_dep = dep + 1'b1;
        end
        4'h6: if (!has2) set_unf = 1'b1;
        else begin
          we0 = 1'b1;
          a0 = ti;
          d0 = s;
          we1 = 1'b1;
          nxt_top = s;
        end
        4'h7: begin
          clr = 1'b1;
          nxt_dep = '0;
          nxt_top = '0;
        end
        default: if (!is_bin) set_ill = 1'b1;
        else if (!has2) set_unf = 1'b1;
        else begin
          we0 = 1'b1;
          a0 = si;
          d0 = res;
          nxt_dep = dep - 1'b1;
          nxt_top = res;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OP;
      dep <= '0;
      top_r <= '0;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
      ill_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.in_valid) begin
      state <= (state == OP && op == 4'h1) ? ARG : OP;
      dep <= nxt_dep;
      top_r <= nxt_top;
      if (we0) mem[a0] <= d0;
      if (we1) mem[a1] <= d1;
      ovf_r <= !clr && (ovf_r || set_ovf);
      unf_r <= !clr && (unf_r || set_unf);
      ill_r <= !clr && (ill_r || set_ill);
    end
  end
  assign bus.top = top_r;
  assign bus.depth = dep;
  assign bus.arg_pend = state == ARG;
  assign bus.ovf = ovf_r;
  assign bus.unf = unf_r;
  assign bus.ill = ill_r;
endmodule

// File: tb/tb_stackcalc_engine.sv
// tb_stackcalc_engine: directed checks of stackcalc_engine (WIDTH=4, DEPTH=8)
module tb_stackcalc_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  stackcalc_if #(.WIDTH(4), .DEPTH(8)) bus ();
  stackcalc_engine #(.WIDTH(4), .DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [3:0] d);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
  endtask
  task automatic push(input logic [3:0] v);
    send(4'h1);
    send(v);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic st(input string tag, input int t, input int d, input int a, input int o, input int u, input int i);
    chk({tag, ".top"}, bus.top, t);
    chk({tag, ".depth"}, bus.depth, d);
    chk({tag, ".arg_pend"}, bus.arg_pend, a);
    chk({tag, ".ovf"}, bus.ovf, o);
    chk({tag, ".unf"}, bus.unf, u);
    chk({tag, ".ill"}, bus.ill, i);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    idle(2);
    rst = 1'b0;
    st("reset", 0, 0, 0, 0, 0, 0);
    push(4'h3);
    send(4'h1);
    st("pend", 3, 1, 1, 0, 0, 0);
    #2 rst = 1'b1;
    #1 st("async_rst", 0, 0, 0, 0, 0, 0);
    idle(1);
    rst = 1'b0;
    idle(1);
    st("post_rst", 0, 0, 0, 0, 0, 0);
    push(4'h3);
    push(4'h4);
    send(4'h3);
    st("add", 7, 1, 0, 0, 0, 0);
    push(4'h2);
    send(4'h4);
    st("sub", 5, 1, 0, 0, 0, 0);
    push(4'h9);
    send(4'h3);
    st("add14", 14, 1, 0, 0, 0, 0);
    push(4'h3);
    send(4'h3);
    st("wrap", 1, 1, 0, 0, 0, 0);
    push(4'h2);
    push(4'h5);
    send(4'h4);
    st("borrow", 13, 2, 0, 0, 0, 0);
    send(4'h7);
    st("clr0", 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) push(4'(i));
    st("fill", 8, 8, 0, 0, 0, 0);
    push(4'hA);
    st("ovf_push", 8, 8, 0, 1, 0, 0);
    send(4'h5);
    st("ovf_dup", 8, 8, 0, 1, 0, 0);
    send(4'h2);
    st("pop_full", 7, 7, 0, 1, 0, 0);
    send(4'h7);
    st("clr_ovf", 0, 0, 0, 0, 0, 0);
    send(4'h2);
    st("unf_pop", 0, 0, 0, 0, 1, 0);
    push(4'h1);
    send(4'h3);
    st("unf_add", 1, 1, 0, 0, 1, 0);
    send(4'h7);
    push(4'h1);
    st("op1_operand", 1, 1, 0, 0, 0, 0);
    push(4'h6);
    send(4'h6);
    st("swap", 1, 2, 0, 0, 0, 0);
    idle(3);
    st("gap", 1, 2, 0, 0, 0, 0);
    send(4'h5);
    st("dup", 1, 3, 0, 0, 0, 0);
    send(4'h2);
    st("pop1", 1, 2, 0, 0, 0, 0);
    send(4'h2);
    st("pop2", 6, 1, 0, 0, 0, 0);
    send(4'h1);
    idle(2);
    st("arg_gap", 6, 1, 1, 0, 0, 0);
    send(4'h2);
    st("arg_pop_val", 2, 2, 0, 0, 0, 0);
    send(4'h7);
    push(4'h3);
    push(4'h5);
    send(4'h8);
`ifdef STACKCALC_MUL_EN
    st("mul", 15, 1, 0, 0, 0, 0);
`else
    st("mul_ill", 5, 2, 0, 0, 0, 1);
`endif
    send(4'hF);
`ifdef STACKCALC_MUL_EN
    st("ill_f", 15, 1, 0, 0, 0, 1);
`else
    st("ill_f", 5, 2, 0, 0, 0, 1);
`endif
    send(4'h7);
    st("clr_ill", 0, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
